// File: rtl/chan_pipe_mixer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : chan_pipe_pkg                                                |
// | Description : Shared mode encodings and stage-constant function for the    |
// |               channel-tagged transform pipeline.                           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package chan_pipe_pkg;

    localparam logic [1:0] MODE_PASS = 2'd0;
    localparam logic [1:0] MODE_XF   = 2'd1;
    localparam logic [1:0] MODE_INV  = 2'd2;
    localparam logic [1:0] MODE_ACC  = 2'd3;

    // Stage constant; callers truncate or zero-extend to their data width.
    function automatic int unsigned stage_k(input int unsigned tag,
                                            input int unsigned depth,
                                            input int unsigned stage);
        return tag * depth + stage + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/chan_pipe_mixer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : chan_pipe_mixer_if                                           |
// | Description : Input and output valid/ready streams of chan_pipe_mixer.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface chan_pipe_mixer_if #(
    parameter int WIDTH = 32,
    parameter int CW    = 3
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in;
    logic [1:0]       mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic [CW-1:0]    out_chan;

    modport master (
        output in_valid, in, mode, out_ready,
        input  in_ready, out_valid, out, out_chan
    );

    modport slave (
        input  in_valid, in, mode, out_ready,
        output in_ready, out_valid, out, out_chan
    );
endinterface
`default_nettype wire

// File: rtl/chan_pipe_mixer_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : chan_pipe_stage                                              |
// | Description : One transform stage: rotate-left-by-one xor stage constant.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module chan_pipe_stage #(
    parameter  int WIDTH = 32,
    parameter  int CW    = 3,
    parameter  int DEPTH = 10,
    parameter  int STAGE = 0,
    localparam int REC_W = 1 + WIDTH + CW + 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [REC_W-1:0] d,
    output logic [REC_W-1:0] q
);
    import chan_pipe_pkg::*;

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] data;
        logic [CW-1:0]    tag;
        logic [1:0]       mode;
    } stage_t;

    stage_t           w_d;
    stage_t           w_next;
    stage_t           r_q;
    logic [WIDTH-1:0] w_k;

    assign w_d = d;
    assign w_k = WIDTH'(stage_k(32'(w_d.tag), 32'(DEPTH), 32'(STAGE)));

    // Bubbles are transformed too; their data is never observed.
    always_comb begin
        w_next = w_d;
        if (w_d.mode != MODE_PASS) begin
            w_next.data = {w_d.data[WIDTH-2:0], w_d.data[WIDTH-1]} ^ w_k;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q <= '0;
        end else if (en) begin
            r_q <= w_next;
        end
    end

    assign q = r_q;
endmodule
`default_nettype wire

// File: rtl/chan_pipe_mixer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : chan_pipe_mixer                                              |
// | Description : Round-robin channel tagging, DEPTH-stage transform pipe,     |
// |               per-beat output mode and per-channel accumulators.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module chan_pipe_mixer #(
    parameter  int WIDTH   = 32,
    parameter  int CHANNEL = 5,
    parameter  int DEPTH   = 10,
    localparam int CW      = (CHANNEL > 1) ? $clog2(CHANNEL) : 1
) (
    input  logic              clk,
    input  logic              rst,
    chan_pipe_mixer_if.slave  bus
);
    import chan_pipe_pkg::*;

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] data;
        logic [CW-1:0]    tag;
        logic [1:0]       mode;
    } stage_t;

    localparam int REC_W = $bits(stage_t);

    logic             w_stall;
    logic             w_en;
    logic             w_accept;
    logic             w_out_fire;
    logic [CW-1:0]    r_chan_cnt;
    logic [REC_W-1:0] w_rec [DEPTH+1];
    stage_t           w_head;
    stage_t           w_last;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out;
    logic [CW-1:0]    r_out_chan;
    logic [1:0]       r_out_mode;
    logic [WIDTH-1:0] r_acc [CHANNEL];
    logic [WIDTH-1:0] w_acc_base;
    logic [WIDTH-1:0] w_out_next;

    assign w_stall      = r_out_valid && !bus.out_ready;
    assign w_en         = !w_stall;
    assign bus.in_ready = w_en && rst;
    assign w_accept     = bus.in_valid && bus.in_ready;
    assign w_out_fire   = r_out_valid && bus.out_ready;

    assign w_head   = '{valid: w_accept, data: bus.in, tag: r_chan_cnt, mode: bus.mode};
    assign w_rec[0] = w_head;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            chan_pipe_stage #(
                .WIDTH (WIDTH),
                .CW    (CW),
                .DEPTH (DEPTH),
                .STAGE (gi)
            ) u_stage (
                .clk (clk),
                .rst (rst),
                .en  (w_en),
                .d   (w_rec[gi]),
                .q   (w_rec[gi+1])
            );
        end
    endgenerate

    assign w_last = w_rec[DEPTH];

    // Forward the accumulator value still sitting in the output register when
    // it belongs to the same channel (only possible with a single channel).
    always_comb begin
        w_acc_base = r_acc[w_last.tag];
        if (r_out_valid && (r_out_mode == MODE_ACC) && (r_out_chan == w_last.tag)) begin
            w_acc_base = r_out;
        end
        case (w_last.mode)
            MODE_INV: w_out_next = ~w_last.data;
            MODE_ACC: w_out_next = w_acc_base + w_last.data;
            default:  w_out_next = w_last.data;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_out       <= '0;
            r_out_chan  <= '0;
            r_out_mode  <= MODE_PASS;
        end else if (w_en) begin
            r_out_valid <= w_last.valid;
            if (w_last.valid) begin
                r_out      <= w_out_next;
                r_out_chan <= w_last.tag;
                r_out_mode <= w_last.mode;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < CHANNEL; c++) begin
                r_acc[c] <= '0;
            end
        end else if (w_out_fire && (r_out_mode == MODE_ACC)) begin
            r_acc[r_out_chan] <= r_out;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_chan_cnt <= '0;
        end else if (w_accept) begin
            r_chan_cnt <= (r_chan_cnt == CW'(CHANNEL - 1)) ? '0 : r_chan_cnt + 1'b1;
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out       = r_out;
    assign bus.out_chan  = r_out_chan;
endmodule
`default_nettype wire
